// File: rtl/debug_report_sequencer.sv
// Debug-unit report sequencer: snapshots PC/cycles/DMEM and serialises a report frame through the UART TX handshake.
// Optional build macro DU_CHECKSUM_EN appends an XOR checksum byte of the payload after DMEM.
module debug_report_sequencer #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_BYTE = 8,
    parameter int unsigned N_REGS  = 32,
    parameter int unsigned NB_ADDR = 5,
    parameter logic [NB_BYTE-1:0] HEADER = NB_BYTE'(8'hA5)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_pc,
    input  logic [NB_DATA-1:0] i_cycles,
    input  logic [NB_DATA-1:0] i_data_memory,
    output logic [NB_ADDR-1:0] o_reg_addr,
    input  logic [NB_DATA-1:0] i_reg_data,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_done
);

    localparam int unsigned NB_PER_WORD = NB_DATA / NB_BYTE;
    localparam int unsigned NB_CNT      = $clog2(NB_PER_WORD + 1);
    localparam int unsigned W_REG_FIRST = 2;
    localparam int unsigned W_REG_LAST  = N_REGS + 1;
    localparam int unsigned W_DMEM      = N_REGS + 2;
`ifdef DU_CHECKSUM_EN
    localparam int unsigned W_CSUM      = N_REGS + 3;
    localparam int unsigned W_LAST      = W_CSUM;
`else
    localparam int unsigned W_LAST      = W_DMEM;
`endif
    localparam int unsigned NB_W        = $clog2(W_LAST + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_LOAD,
        ST_LATCH,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [NB_DATA-1:0]   shift_q, shift_d;
    logic [NB_CNT-1:0]    bytes_left_q, bytes_left_d;
    logic [NB_W-1:0]      w_q, w_d;
    logic                 in_hdr_q, in_hdr_d;
    logic [NB_DATA-1:0]   pc_q, pc_d;
    logic [NB_DATA-1:0]   cycles_q, cycles_d;
    logic [NB_DATA-1:0]   dmem_q, dmem_d;
    logic [NB_ADDR-1:0]   reg_addr_q, reg_addr_d;
    logic [NB_BYTE-1:0]   tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef DU_CHECKSUM_EN
    logic [NB_BYTE-1:0]   csum_q, csum_d;
`endif

    // State and datapath registers
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bytes_left_q <= '0;
            w_q          <= '0;
            in_hdr_q     <= 1'b0;
            pc_q         <= '0;
            cycles_q     <= '0;
            dmem_q       <= '0;
            reg_addr_q   <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef DU_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bytes_left_q <= bytes_left_d;
            w_q          <= w_d;
            in_hdr_q     <= in_hdr_d;
            pc_q         <= pc_d;
            cycles_q     <= cycles_d;
            dmem_q       <= dmem_d;
            reg_addr_q   <= reg_addr_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef DU_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bytes_left_d = bytes_left_q;
        w_d          = w_q;
        in_hdr_d     = in_hdr_q;
        pc_d         = pc_q;
        cycles_d     = cycles_q;
        dmem_d       = dmem_q;
        reg_addr_d   = reg_addr_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        done_d       = 1'b0;
`ifdef DU_CHECKSUM_EN
        csum_d       = csum_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    pc_d     = i_pc;
                    cycles_d = i_cycles;
                    dmem_d   = i_data_memory;
                    w_d      = '0;
                    in_hdr_d = 1'b1;
`ifdef DU_CHECKSUM_EN
                    csum_d   = '0;
`endif
                    state_d  = ST_HEADER;
                end
            end

            ST_HEADER: begin
                shift_d      = {HEADER, {(NB_DATA - NB_BYTE){1'b0}}};
                bytes_left_d = NB_CNT'(1);
                state_d      = ST_SEND;
            end

            ST_LOAD: begin
                if (w_q >= NB_W'(W_REG_FIRST) && w_q <= NB_W'(W_REG_LAST)) begin
                    reg_addr_d = NB_ADDR'(w_q - NB_W'(W_REG_FIRST));
                end
                state_d = ST_LATCH;
            end

            ST_LATCH: begin
                bytes_left_d = NB_CNT'(NB_PER_WORD);
                if (w_q == NB_W'(0)) begin
                    shift_d = pc_q;
                end else if (w_q == NB_W'(1)) begin
                    shift_d = cycles_q;
                end else if (w_q == NB_W'(W_DMEM)) begin
                    shift_d = dmem_q;
`ifdef DU_CHECKSUM_EN
                end else if (w_q == NB_W'(W_CSUM)) begin
                    shift_d      = {csum_q, {(NB_DATA - NB_BYTE){1'b0}}};
                    bytes_left_d = NB_CNT'(1);
`endif
                end else begin
                    shift_d = i_reg_data;
                end
                state_d = ST_SEND;
            end

            ST_SEND: begin
                tx_data_d  = shift_q[NB_DATA-1 -: NB_BYTE];
                tx_start_d = 1'b1;
`ifdef DU_CHECKSUM_EN
                // Header and the checksum byte itself stay out of the sum
                if (!in_hdr_q && w_q != NB_W'(W_CSUM)) begin
                    csum_d = csum_q ^ shift_q[NB_DATA-1 -: NB_BYTE];
                end
`endif
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (i_tx_done) begin
                    shift_d      = shift_q << NB_BYTE;
                    bytes_left_d = bytes_left_q - NB_CNT'(1);
                    if (bytes_left_q > NB_CNT'(1)) begin
                        state_d = ST_SEND;
                    end else if (in_hdr_q) begin
                        // Header done: word index stays at 0 (PC)
                        in_hdr_d = 1'b0;
                        state_d  = ST_LOAD;
                    end else if (w_q == NB_W'(W_LAST)) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        w_d     = w_q + NB_W'(1);
                        state_d = ST_LOAD;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    assign o_reg_addr = reg_addr_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_debug_report_sequencer.sv
// Randomised bench for debug_report_sequencer: a queue-based frame model drives byte, latency and handshake checks.
module tb_debug_report_sequencer;

    localparam int unsigned NB_DATA = 32;
    localparam int unsigned NB_BYTE = 8;
    localparam int unsigned N_REGS  = 32;
    localparam int unsigned NB_ADDR = 5;
`ifdef DU_CHECKSUM_EN
    localparam int unsigned FRAME_LEN = 1 + 4 * (N_REGS + 3) + 1;
`else
    localparam int unsigned FRAME_LEN = 1 + 4 * (N_REGS + 3);
`endif

    logic               i_clock = 1'b0;
    logic               i_reset;
    logic               i_start;
    logic [NB_DATA-1:0] i_pc;
    logic [NB_DATA-1:0] i_cycles;
    logic [NB_DATA-1:0] i_data_memory;
    logic [NB_ADDR-1:0] o_reg_addr;
    logic [NB_DATA-1:0] i_reg_data;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               o_tx_start;
    logic               i_tx_done;
    logic               o_busy;
    logic               o_done;

    logic [NB_DATA-1:0] regs [N_REGS];

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;
    int done_cnt  = 0;

    debug_report_sequencer dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_pc          (i_pc),
        .i_cycles      (i_cycles),
        .i_data_memory (i_data_memory),
        .o_reg_addr    (o_reg_addr),
        .i_reg_data    (i_reg_data),
        .o_tx_data     (o_tx_data),
        .o_tx_start    (o_tx_start),
        .i_tx_done     (i_tx_done),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    assign i_reg_data = regs[o_reg_addr];

    always #5 i_clock = ~i_clock;

    always @(negedge i_clock) begin
        if (o_tx_start) start_cnt++;
        if (o_done) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge i_clock);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_reg_addr"}, 32'(o_reg_addr), 0);
        check_eq({tag, "_tx_data"},  32'(o_tx_data), 0);
        check_eq({tag, "_tx_start"}, 32'(o_tx_start), 0);
        check_eq({tag, "_busy"},     32'(o_busy), 0);
        check_eq({tag, "_done"},     32'(o_done), 0);
    endtask

    // One report frame against the expected byte stream; abort_after>0 resets after that many bytes
    task automatic run_frame(input logic [31:0] pc, input logic [31:0] cyc, input logic [31:0] dmem,
                             input int gap_min, input int gap_max, input bit change_pc,
                             input bit poke, input bit spur, input bit start_on_done,
                             input int abort_after);
        logic [7:0] exp_q[$];
        logic [31:0] words[$];
        logic [7:0] cs;
        int n, gap, lat_exp, s0, d0;
        bit use_spur;

        words.push_back(pc);
        words.push_back(cyc);
        for (int r = 0; r < int'(N_REGS); r++) words.push_back(regs[r]);
        words.push_back(dmem);
        exp_q.push_back(8'hA5);
        cs = 8'h00;
        foreach (words[i]) begin
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back(words[i][b*8 +: 8]);
                cs ^= words[i][b*8 +: 8];
            end
        end
`ifdef DU_CHECKSUM_EN
        exp_q.push_back(cs);
`endif

        i_pc = pc;
        i_cycles = cyc;
        i_data_memory = dmem;
        s0 = start_cnt;
        d0 = done_cnt;
        i_start = 1'b1;
        step;
        i_start = 1'b0;
        check_eq("busy_after_accept", 32'(o_busy), 1);
        if (change_pc) begin
            i_pc = 32'hFFFF_FFFF;
            i_cycles = ~cyc;
            i_data_memory = ~dmem;
        end
        lat_exp = 2;

        for (int k = 0; k < exp_q.size(); k++) begin
            n = 0;
            while (!o_tx_start && n < 60) begin
                step;
                n++;
            end
            if (!o_tx_start) begin
                check_eq($sformatf("tx_start_timeout_byte%0d", k), 32'(o_tx_start), 1);
                return;
            end
            check_eq($sformatf("latency_byte%0d", k), 32'(n), 32'(lat_exp));
            check_eq($sformatf("byte%0d", k), 32'(o_tx_data), 32'(exp_q[k]));
            check_eq("busy_mid_frame", 32'(o_busy), 1);

            if (abort_after > 0 && k + 1 == abort_after) begin
                i_reset = 1'b1;
                #1;
                check_idle_outputs("abort");
                step;
                step;
                i_reset = 1'b0;
                step;
                check_idle_outputs("abort_release");
                check_eq("abort_no_done", 32'(done_cnt - d0), 0);
                return;
            end

            gap = $urandom_range(gap_max, gap_min);
            step;
            check_eq("tx_start_one_cycle", 32'(o_tx_start), 0);
            for (int g = 1; g < gap; g++) begin
                i_start = poke && (k % 7 == 3);
                step;
                i_start = 1'b0;
            end
            check_eq($sformatf("tx_data_hold%0d", k), 32'(o_tx_data), 32'(exp_q[k]));

            use_spur = spur && (k % 3 == 1) && (k < exp_q.size() - 1);
            i_tx_done = 1'b1;
            step;
            if (use_spur) step;
            i_tx_done = 1'b0;
            lat_exp = ((k + 1) % 4 == 1) ? 3 : 1;
            if (use_spur) lat_exp = lat_exp - 1;
        end

        check_eq("done_pulse", 32'(o_done), 1);
        check_eq("busy_in_done", 32'(o_busy), 0);
        if (start_on_done) i_start = 1'b1;
        step;
        i_start = 1'b0;
        check_eq("done_clears", 32'(o_done), 0);
        check_eq("idle_busy", 32'(o_busy), 0);
        step;
        check_eq("start_on_done_ignored", 32'(o_busy), 0);
        check_eq("tx_start_count", 32'(start_cnt - s0), 32'(FRAME_LEN));
        check_eq("done_count", 32'(done_cnt - d0), 1);
    endtask

    initial begin
        i_reset = 1'b1;
        i_start = 1'b0;
        i_tx_done = 1'b0;
        i_pc = '0;
        i_cycles = '0;
        i_data_memory = '0;
        for (int r = 0; r < int'(N_REGS); r++) regs[r] = '0;
        step;
        step;
        check_idle_outputs("reset");
        i_reset = 1'b0;
        step;
        check_idle_outputs("post_reset");

        // Fixed reference frame with 5-clock UART
        for (int r = 0; r < int'(N_REGS); r++) regs[r] = 32'(r);
        run_frame(32'h0000_0040, 32'd7, 32'hDEAD_BEEF, 5, 5, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Snapshot: inputs change right after accept, spurious tx_done held into SEND
        run_frame(32'h0000_0040, 32'd7, 32'hDEAD_BEEF, 1, 4, 1'b1, 1'b0, 1'b1, 1'b0, 0);

        // i_start pokes while busy and coincident with DONE
        run_frame($urandom, $urandom, $urandom, 1, 6, 1'b0, 1'b1, 1'b1, 1'b1, 0);

        // Reset abort after 10 bytes, then a fresh frame
        run_frame($urandom, $urandom, $urandom, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        run_frame(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Checksum corner: 1^2^3 == 0
        for (int r = 0; r < int'(N_REGS); r++) regs[r] = '0;
        run_frame(32'd1, 32'd2, 32'd3, 1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Fully random frames
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < int'(N_REGS); r++) regs[r] = $urandom;
            run_frame($urandom, $urandom, $urandom, 1, 4, f[0], 1'b1, 1'b1, f[0], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
